// File: rtl/jtdd_video_pkg.sv
// jtdd_video_pkg: DD raster timing defaults shared by the video timer and its users.
package jtdd_video_pkg;

    localparam int DD_HTOTAL   = 384;
    localparam int DD_HB_START = 256;
    localparam int DD_VSTART   = 8;
    localparam int DD_VLAST    = 255;
    localparam int DD_VB_START = 248;
    localparam int DD_PHASES   = 6;

endpackage

// File: rtl/jtdd_vtimer_if.sv
// jtdd_vtimer_if: video timing and interrupt signals between the raster timer and its consumers.
interface jtdd_vtimer_if
    import jtdd_video_pkg::*;
#(
    parameter int HW     = 9,
    parameter int VW     = 8,
    parameter int PHASES = DD_PHASES
);
    logic              pxl_cen;
    logic              flip;
    logic [HW-2:0]     hpos;
    logic [VW-1:0]     vpos;
    logic [HW-1:0]     hn_raw;
    logic [VW-1:0]     vn_raw;
    logic              HBL;
    logic              VBL;
    logic              HS;
    logic              VS;
    logic [PHASES-1:0] M;
    logic [7:0]        frame;
    logic              vbl_irq;
    logic              irq_ack;
    logic [VW-1:0]     lirq_line;
    logic              lirq;

    modport master (
        input  pxl_cen, flip, irq_ack, lirq_line,
        output hpos, vpos, hn_raw, vn_raw, HBL, VBL, HS, VS, M, frame, vbl_irq, lirq
    );

    modport slave (
        output pxl_cen, flip, irq_ack, lirq_line,
        input  hpos, vpos, hn_raw, vn_raw, HBL, VBL, HS, VS, M, frame, vbl_irq, lirq
    );
endinterface

// File: rtl/jtdd_vtimer_irq.sv
// jtdd_vtimer_irq: level interrupt latch; a set in the same clk as an ack keeps the request.
module jtdd_vtimer_irq (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic ack,
    output logic q
);
    always_ff @(posedge clk) begin
        if (!rst)     q <= 1'b0;
        else if (set) q <= 1'b1;
        else if (ack) q <= 1'b0;
    end
endmodule

// File: rtl/jtdd_vtimer.sv
// jtdd_vtimer: parametrised raster timing generator (counters, blanking, sync, bus phases, IRQs).
// Define JTDD_VTIMER_LIRQ_EN to build the line-compare interrupt.
module jtdd_vtimer
    import jtdd_video_pkg::*;
#(
    parameter int HW       = 9,
    parameter int VW       = 8,
    parameter int HTOTAL   = DD_HTOTAL,
    parameter int HB_START = DD_HB_START,
    parameter int HS_START = 320,
    parameter int HS_LEN   = 32,
    parameter int VSTART   = DD_VSTART,
    parameter int VLAST    = DD_VLAST,
    parameter int VB_START = DD_VB_START,
    parameter int VS_START = 252,
    parameter int VS_LEN   = 3,
    parameter int PHASES   = DD_PHASES
) (
    input  logic          clk,
    input  logic          rst,
    jtdd_vtimer_if.master bus
);
    if (HB_START >= HTOTAL) begin : g_chk_hb
        $error("jtdd_vtimer: HB_START must be below HTOTAL");
    end
    if (VSTART > VLAST) begin : g_chk_v
        $error("jtdd_vtimer: VSTART must not exceed VLAST");
    end
    if (HS_START + HS_LEN > HTOTAL) begin : g_chk_hs
        $error("jtdd_vtimer: HS pulse runs past the end of the line");
    end

    localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_BLK   = HW'(HB_START);
    localparam logic [HW:0]   H_SYN0  = (HW+1)'(HS_START);
    localparam logic [HW:0]   H_SYN1  = (HW+1)'(HS_START + HS_LEN);
    localparam logic [VW-1:0] V_FIRST = VW'(VSTART);
    localparam logic [VW-1:0] V_LAST  = VW'(VLAST);
    localparam logic [VW-1:0] V_BLK   = VW'(VB_START);
    localparam logic [VW-1:0] V_SYN   = VW'(VS_START);
    localparam logic [VW-1:0] VS_CNT  = VW'(VS_LEN - 1);

    logic [HW-1:0]     hn, hn_nx;
    logic [VW-1:0]     vn, vn_nx, vs_left, vpos;
    logic              line_end, frame_end;
    logic              hbl, vbl, hs, vs, hs_nx;
    logic [PHASES-1:0] m, m_nx;
    logic [7:0]        frame;
    logic              vbl_set;

    always_comb begin
        line_end  = (hn == H_LAST);
        frame_end = line_end && (vn == V_LAST);
        hn_nx     = line_end ? '0 : hn + 1'b1;
        vn_nx     = vn;
        if (line_end) vn_nx = (vn == V_LAST) ? V_FIRST : vn + 1'b1;
        hs_nx     = ({1'b0, hn_nx} >= H_SYN0) && ({1'b0, hn_nx} < H_SYN1);
        vbl_set   = bus.pxl_cen && line_end && (vn_nx == V_BLK);
        // Bus phase k is active on the odd pixel 2k+1 of the upcoming position.
        m_nx      = '0;
        for (int k = 0; k < PHASES; k++)
            m_nx[k] = hn_nx[0] && (hn_nx[HW-1:1] == (HW-1)'(k));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hn      <= '0;
            vn      <= V_BLK;
            hbl     <= 1'b0;
            vbl     <= 1'b1;
            hs      <= 1'b0;
            vs      <= 1'b0;
            vs_left <= '0;
            m       <= '0;
            frame   <= '0;
        end else if (bus.pxl_cen) begin
            hn <= hn_nx;
            vn <= vn_nx;
            hs <= hs_nx;
            m  <= m_nx;
            if (hn_nx == H_BLK) hbl <= 1'b1;
            else if (line_end)  hbl <= 1'b0;
            if (line_end) begin
                if (vn_nx == V_BLK)  vbl <= 1'b1;
                else if (frame_end) vbl <= 0;
                if (frame_end) frame <= frame + 8'd1;
                // VS counts whole lines so it can straddle the VLAST->VSTART wrap.
                if (vn_nx == V_SYN) begin
                    vs      <= 1'b1;
                    vs_left <= VS_CNT;
                end else if (vs_left != '0) begin
                    vs_left <= vs_left - 1'b1;
                end else begin
                    vs <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) vpos <= vn ^ {VW{bus.flip}};

    jtdd_vtimer_irq u_vbl_irq (
        .clk (clk),
        .rst (rst),
        .set (vbl_set),
        .ack (bus.irq_ack),
        .q   (bus.vbl_irq)
    );

`ifdef JTDD_VTIMER_LIRQ_EN
    logic lirq_set;
    assign lirq_set = bus.pxl_cen && (hn_nx == H_BLK) && (vn == bus.lirq_line);

    jtdd_vtimer_irq u_line_irq (
        .clk (clk),
        .rst (rst),
        .set (lirq_set),
        .ack (bus.irq_ack),
        .q   (bus.lirq)
    );
`else
    logic unused_lirq_line;
    assign unused_lirq_line = ^bus.lirq_line;
    assign bus.lirq         = 1'b0;
`endif

    assign bus.hpos   = hn[HW-2:0] ^ {(HW-1){bus.flip}};
    assign bus.vpos   = vpos;
    assign bus.hn_raw = hn;
    assign bus.vn_raw = vn;
    assign bus.HBL    = hbl;
    assign bus.VBL    = vbl;
    assign bus.HS     = hs;
    assign bus.VS     = vs;
    assign bus.M      = m;
    assign bus.frame  = frame;
endmodule

// File: tb/tb_jtdd_vtimer.sv
// tb_jtdd_vtimer: default-timing instance driven by directed tables and sequences, plus a
// small-timing instance under random stimulus, both compared against a frame-position model.
`timescale 1ns/1ps
module tb_jtdd_vtimer;

    typedef struct {
        int htotal, hb, hs, hs_len, vstart, vlast, vb, vs, vs_len, phases;
    } tp_t;

    typedef struct packed {
        logic [8:0] hn;
        logic [7:0] vn;
        logic       hbl, vbl, hs, vs;
        logic [5:0] m;
        logic [7:0] frame;
        logic       irq, lirq;
        logic [7:0] hpos, vpos;
    } obs_t;

    typedef struct {
        int         t, hn, vn;
        logic [5:0] m;
        logic       hbl, hs, vbl, vs;
        int         frame;
    } vec_t;

    localparam tp_t TA = '{384, 256, 320, 32, 8, 255, 248, 252, 3, 6};
    localparam tp_t TB = '{40, 30, 33, 4, 8, 20, 16, 19, 3, 6};

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   checks = 0, failures = 0;
    bit   chk_a = 0, chk_b = 0;

    jtdd_vtimer_if #(.HW(9), .VW(8), .PHASES(6)) ifa ();
    jtdd_vtimer_if #(.HW(9), .VW(8), .PHASES(6)) ifb ();

    jtdd_vtimer u_a (.clk(clk), .rst(rst_a), .bus(ifa));

    jtdd_vtimer #(
        .HW(9), .VW(8), .HTOTAL(40), .HB_START(30), .HS_START(33), .HS_LEN(4),
        .VSTART(8), .VLAST(20), .VB_START(16), .VS_START(19), .VS_LEN(3), .PHASES(6)
    ) u_b (.clk(clk), .rst(rst_b), .bus(ifb));

    always #5 clk = ~clk;

    // ---------------- reference model: position derived from the cen count since reset
    function automatic int vn_of(input tp_t p, input int t);
        int nl, pos;
        nl  = p.vlast - p.vstart + 1;
        pos = p.vb - p.vstart + t / p.htotal;
        return p.vstart + pos % nl;
    endfunction

    function automatic obs_t model_out(input tp_t p, input int t, input logic flip,
                                       input logic irq, input logic lirq, input logic [7:0] vpos);
        obs_t o;
        int hn, vn, nl, pos, d;
        hn  = t % p.htotal;
        nl  = p.vlast - p.vstart + 1;
        pos = p.vb - p.vstart + t / p.htotal;
        vn  = p.vstart + pos % nl;
        d   = (vn >= p.vs) ? vn - p.vs : vn - p.vstart + p.vlast - p.vs + 1;
        o.hn    = 9'(hn);
        o.vn    = 8'(vn);
        o.hbl   = hn >= p.hb;
        o.vbl   = vn >= p.vb;
        o.hs    = (hn >= p.hs) && (hn < p.hs + p.hs_len);
        o.vs    = d < p.vs_len;
        o.m     = '0;
        if ((hn % 2 == 1) && (hn / 2 < p.phases)) o.m[hn/2] = 1'b1;
        o.frame = 8'((pos / nl) % 256);
        o.irq   = irq;
        o.lirq  = lirq;
        o.hpos  = 8'(hn) ^ {8{flip}};
        o.vpos  = vpos;
        return o;
    endfunction

    task automatic model_step(input tp_t p, input logic rstn, input logic cen, input logic flip,
                              input logic ack, input logic [7:0] line, inout int t,
                              inout logic irq, inout logic lirq, output logic [7:0] vp);
        logic set_v, set_l;
        vp = 8'(vn_of(p, t)) ^ {8{flip}};
        if (!rstn) begin
            t = 0; irq = 1'b0; lirq = 1'b0;
        end else begin
            set_v = 1'b0;
            set_l = 1'b0;
            if (cen) begin
                set_v = ((t + 1) % p.htotal == 0) && (vn_of(p, t + 1) == p.vb);
                set_l = ((t + 1) % p.htotal == p.hb) && (vn_of(p, t) == int'(line));
                t++;
            end
            irq = set_v | (irq & ~ack);
`ifdef JTDD_VTIMER_LIRQ_EN
            lirq = set_l | (lirq & ~ack);
`else
            lirq = 1'b0;
`endif
        end
    endtask

    int         ta = 0, tb = 0;
    logic       irqa = 0, lirqa = 0, irqb = 0, lirqb = 0;
    logic [7:0] vpa = 0, vpb = 0;

    always @(posedge clk)
        model_step(TA, rst_a, ifa.pxl_cen, ifa.flip, ifa.irq_ack, ifa.lirq_line, ta, irqa, lirqa, vpa);
    always @(posedge clk)
        model_step(TB, rst_b, ifb.pxl_cen, ifb.flip, ifb.irq_ack, ifb.lirq_line, tb, irqb, lirqb, vpb);

    obs_t obs_a, obs_b;
    assign obs_a = {ifa.hn_raw, ifa.vn_raw, ifa.HBL, ifa.VBL, ifa.HS, ifa.VS, ifa.M, ifa.frame,
                    ifa.vbl_irq, ifa.lirq, ifa.hpos, ifa.vpos};
    assign obs_b = {ifb.hn_raw, ifb.vn_raw, ifb.HBL, ifb.VBL, ifb.HS, ifb.VS, ifb.M, ifb.frame,
                    ifb.vbl_irq, ifb.lirq, ifb.hpos, ifb.vpos};

    task automatic check_obs(input string nm, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h (hn,vn,hbl,vbl,hs,vs,m,frame,irq,lirq,hpos,vpos)",
                     nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_a) check_obs("model_A", obs_a, model_out(TA, ta, ifa.flip, irqa, lirqa, vpa));
        if (chk_b) check_obs("model_B", obs_b, model_out(TB, tb, ifb.flip, irqb, lirqb, vpb));
    end

    // ---------------- directed helpers
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int cur_a = 0;
    task automatic step_to(input int target);
        repeat (target - cur_a) tick();
        cur_a = target;
    endtask

    // ---------------- instance A: default DD timing
    task automatic seq_a();
        vec_t tab[$];
        tab.push_back('{1,    1,   248, 6'b000001, 0, 0, 1, 0, 0});
        tab.push_back('{2,    2,   248, 6'b000000, 0, 0, 1, 0, 0});
        tab.push_back('{3,    3,   248, 6'b000010, 0, 0, 1, 0, 0});
        tab.push_back('{5,    5,   248, 6'b000100, 0, 0, 1, 0, 0});
        tab.push_back('{7,    7,   248, 6'b001000, 0, 0, 1, 0, 0});
        tab.push_back('{9,    9,   248, 6'b010000, 0, 0, 1, 0, 0});
        tab.push_back('{11,   11,  248, 6'b100000, 0, 0, 1, 0, 0});
        tab.push_back('{13,   13,  248, 6'b000000, 0, 0, 1, 0, 0});
        tab.push_back('{15,   15,  248, 6'b000000, 0, 0, 1, 0, 0});
        tab.push_back('{255,  255, 248, 6'b000000, 0, 0, 1, 0, 0});
        tab.push_back('{256,  256, 248, 6'b000000, 1, 0, 1, 0, 0});
        tab.push_back('{319,  319, 248, 6'b000000, 1, 0, 1, 0, 0});
        tab.push_back('{320,  320, 248, 6'b000000, 1, 1, 1, 0, 0});
        tab.push_back('{351,  351, 248, 6'b000000, 1, 1, 1, 0, 0});
        tab.push_back('{352,  352, 248, 6'b000000, 1, 0, 1, 0, 0});
        tab.push_back('{383,  383, 248, 6'b000000, 1, 0, 1, 0, 0});
        tab.push_back('{384,  0,   249, 6'b000000, 0, 0, 1, 0, 0});
        tab.push_back('{1535, 383, 251, 6'b000000, 1, 0, 1, 0, 0});
        tab.push_back('{1536, 0,   252, 6'b000000, 0, 0, 1, 1, 0});
        tab.push_back('{2687, 383, 254, 6'b000000, 1, 0, 1, 1, 0});
        tab.push_back('{2688, 0,   255, 6'b000000, 0, 0, 1, 0, 0});
        tab.push_back('{3071, 383, 255, 6'b000000, 1, 0, 1, 0, 0});
        tab.push_back('{3072, 0,   8,   6'b000000, 0, 0, 0, 0, 1});

        rst_a = 1'b0; ifa.pxl_cen = 1'b0; ifa.flip = 1'b0; ifa.irq_ack = 1'b0;
        ifa.lirq_line = 8'd100;
        repeat (3) tick();
        chk_a = 1;
        chk("A_rst_vn", 32'(ifa.vn_raw), 32'd248);
        chk("A_rst_vbl", 32'(ifa.VBL), 32'd1);
        chk("A_rst_hn", 32'(ifa.hn_raw), 32'd0);
        chk("A_rst_frame", 32'(ifa.frame), 32'd0);
        chk("A_rst_irq", 32'(ifa.vbl_irq), 32'd0);
        chk("A_rst_hbl_hs_vs", 32'({ifa.HBL, ifa.HS, ifa.VS}), 32'd0);
        chk("A_rst_m", 32'(ifa.M), 32'd0);
        chk("A_rst_lirq", 32'(ifa.lirq), 32'd0);
        rst_a = 1'b1;
        ifa.pxl_cen = 1'b1;

        foreach (tab[i]) begin
            step_to(tab[i].t);
            chk($sformatf("A_tab%0d_hn", i), 32'(ifa.hn_raw), 32'(tab[i].hn));
            chk($sformatf("A_tab%0d_vn", i), 32'(ifa.vn_raw), 32'(tab[i].vn));
            chk($sformatf("A_tab%0d_m", i), 32'(ifa.M), 32'(tab[i].m));
            chk($sformatf("A_tab%0d_hbl_hs", i), 32'({ifa.HBL, ifa.HS}), 32'({tab[i].hbl, tab[i].hs}));
            chk($sformatf("A_tab%0d_vbl_vs", i), 32'({ifa.VBL, ifa.VS}), 32'({tab[i].vbl, tab[i].vs}));
            chk($sformatf("A_tab%0d_frame", i), 32'(ifa.frame), 32'(tab[i].frame));
        end

        // flip at vn=10, hn=5, then a frozen pixel clock
        step_to(3072 + 2 * 384 + 5);
        ifa.flip = 1'b1; ifa.pxl_cen = 1'b0;
        tick();
        chk("A_flip_vpos", 32'(ifa.vpos), 32'hF5);
        chk("A_flip_hpos", 32'(ifa.hpos), 32'hFA);
        repeat (10) tick();
        chk("A_hold_hn", 32'(ifa.hn_raw), 32'd5);
        chk("A_hold_vn", 32'(ifa.vn_raw), 32'd10);
        ifa.flip = 1'b0;
        tick();
        chk("A_unflip_vpos", 32'(ifa.vpos), 32'h0A);
        chk("A_unflip_hpos", 32'(ifa.hpos), 32'h05);
        ifa.pxl_cen = 1'b1;

        // line-compare interrupt at vn=100, hn=256
        step_to(3072 + 92 * 384 + 255);
        chk("A_lirq_before", 32'(ifa.lirq), 32'd0);
        step_to(3072 + 92 * 384 + 258);
        chk("A_lirq_vn", 32'(ifa.vn_raw), 32'd100);
`ifdef JTDD_VTIMER_LIRQ_EN
        chk("A_lirq_set", 32'(ifa.lirq), 32'd1);
`else
        chk("A_lirq_off", 32'(ifa.lirq), 32'd0);
`endif
        ifa.pxl_cen = 1'b0; ifa.irq_ack = 1'b1;
        tick();
        ifa.irq_ack = 1'b0;
        chk("A_lirq_ack", 32'({ifa.lirq, ifa.vbl_irq}), 32'd0);
        tick();
    endtask

    // ---------------- instance B: compact timing, random stimulus, VBL IRQ handshake
    task automatic seq_b();
        bit found;
        rst_b = 1'b0; ifb.pxl_cen = 1'b0; ifb.flip = 1'b0; ifb.irq_ack = 1'b0;
        ifb.lirq_line = 8'd12;
        repeat (3) tick();
        chk_b = 1;
        rst_b = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            ifb.pxl_cen = ($urandom % 4) != 0;
            ifb.flip    = 1'($urandom % 2);
            ifb.irq_ack = ($urandom % 8) == 0;
            rst_b       = ($urandom % 500) != 0;
            if ($urandom % 64 == 0) ifb.lirq_line = 8'($urandom_range(8, 20));
            tick();
        end

        // Reach the wrap into VB_START with ack held high on that very clk.
        rst_b = 1'b1; ifb.pxl_cen = 1'b1; ifb.irq_ack = 1'b1;
        found = 0;
        for (int i = 0; i < 2 * 40 * 13 && !found; i++) begin
            if (((tb + 1) % TB.htotal == 0) && (vn_of(TB, tb + 1) == TB.vb)) found = 1;
            else tick();
        end
        chk("B_vbl_seek", 32'(found), 32'd1);
        tick();
        chk("B_vbl_vn", 32'(ifb.vn_raw), 32'd16);
        chk("B_vbl_set", 32'(ifb.VBL), 32'd1);
        chk("B_irq_set_wins", 32'(ifb.vbl_irq), 32'd1);
        ifb.pxl_cen = 1'b0;
        tick();
        chk("B_irq_ack", 32'(ifb.vbl_irq), 32'd0);
        ifb.irq_ack = 1'b0;
        tick();
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            seq_a();
            seq_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
